// File: rtl/p256_limb_squarer_pkg.sv
// ---------------------------------------------------------------------------
// p256_limb_squarer_pkg
// Shared constants and the controller state type for the 256-bit limb
// squarer. Imported by the squarer top and its arithmetic sub-modules.
// ---------------------------------------------------------------------------
package p256_limb_squarer_pkg;

    localparam int LIMB_W  = 32;   // limb width in bits
    localparam int N_LIMBS = 8;    // operand limbs
    localparam int N_COLS  = 16;   // product columns (2 * N_LIMBS)
    localparam int LATENCY = 91;   // enabled edges from reset release to rdy

    typedef enum logic [2:0] {
        ST_LOAD       = 3'd0,
        ST_MUL        = 3'd1,
        ST_ACC        = 3'd2,
        ST_CARRY_PROP = 3'd3,
        ST_FINISH     = 3'd4,
        ST_DONE       = 3'd5
    } state_e;

endpackage

// File: rtl/p256_limb_squarer_cpa.sv
// ---------------------------------------------------------------------------
// cpa
// Carry-propagate adder used for column accumulation. Wraps modulo
// 2^WIDTH; callers size operands so that never happens.
//   a, b : WIDTH-bit addends
//   sum  : WIDTH-bit sum
// ---------------------------------------------------------------------------
module cpa #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/p256_limb_squarer_mul.sv
// ---------------------------------------------------------------------------
// limb_mul32
// Combinational 32x32 -> 64 unsigned limb multiplier. The squarer registers
// its output in the MUL step.
//   a, b : 32-bit unsigned limbs
//   p    : 64-bit unsigned product
// ---------------------------------------------------------------------------
module limb_mul32
    import p256_limb_squarer_pkg::*;
(
    input  logic [LIMB_W-1:0]   a,
    input  logic [LIMB_W-1:0]   b,
    output logic [2*LIMB_W-1:0] p
);

    assign p = {{LIMB_W{1'b0}}, a} * {{LIMB_W{1'b0}}, b};

endmodule

// File: rtl/p256_limb_squarer.sv
// ---------------------------------------------------------------------------
// p256_limb_squarer
// Multi-cycle 256-bit squarer producing the full 512-bit square using one
// 32x32 limb multiply per product step. Visits the 36 limb pairs i<=j,
// doubling off-diagonal products into 64-bit column accumulators, then runs
// a 16-step serial carry pass and publishes the low 32 bits of each column.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   ena     : advance enable; all state holds while low
//   a_in    : 256-bit operand, sampled in LOAD only
//   rdy     : result valid, sticky until reset
//   sq_high : bits 511:256 of a_in^2
//   sq_low  : bits 255:0 of a_in^2
// ---------------------------------------------------------------------------
module p256_limb_squarer
    import p256_limb_squarer_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic [255:0] a_in,
    output logic         rdy,
    output logic [255:0] sq_high,
    output logic [255:0] sq_low
);

    state_e              state_q, state_d;
    logic [LIMB_W-1:0]   a_q   [N_LIMBS];
    logic [LIMB_W-1:0]   a_d   [N_LIMBS];
    logic [63:0]         col_q [N_COLS];
    logic [63:0]         col_d [N_COLS];
    logic [2:0]          i_q, i_d, j_q, j_d;
    logic [3:0]          k_q, k_d;
    logic [63:0]         p_q, p_d;
    logic [63:0]         carry_q, carry_d;
    logic                rdy_q, rdy_d;
    logic [255:0]        sq_high_q, sq_high_d;
    logic [255:0]        sq_low_q, sq_low_d;

    logic [63:0] mul_p;
    logic [3:0]  col_lo_idx, col_hi_idx;
    logic        dbl;
    logic [63:0] add0_a, add0_b, add0_sum;
    logic [63:0] add1_a, add1_b, add1_sum;

    limb_mul32 u_mul (
        .a (a_q[i_q]),
        .b (a_q[j_q]),
        .p (mul_p)
    );

    // Adder 0 serves the low half of a product in ACC and is reused for
    // col[k] + carry during CARRY_PROP; adder 1 serves the high half.
    always_comb begin
        dbl        = (i_q != j_q);   // off-diagonal terms appear twice in a square
        col_lo_idx = {1'b0, i_q} + {1'b0, j_q};
        col_hi_idx = col_lo_idx + 4'd1;
        if (state_q == ST_CARRY_PROP) begin
            add0_a = col_q[k_q];
            add0_b = carry_q;
        end else begin
            add0_a = col_q[col_lo_idx];
            add0_b = dbl ? {31'b0, p_q[31:0], 1'b0} : {32'b0, p_q[31:0]};
        end
        add1_a = col_q[col_hi_idx];
        add1_b = dbl ? {31'b0, p_q[63:32], 1'b0} : {32'b0, p_q[63:32]};
    end

    cpa #(.WIDTH(64)) u_add0 (.a(add0_a), .b(add0_b), .sum(add0_sum));
    cpa #(.WIDTH(64)) u_add1 (.a(add1_a), .b(add1_b), .sum(add1_sum));

    // NOTE: every _d gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis would infer latches.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        col_d     = col_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        p_d       = p_q;
        carry_d   = carry_q;
        rdy_d     = rdy_q;
        sq_high_d = sq_high_q;
        sq_low_d  = sq_low_q;

        case (state_q)
            ST_LOAD: begin
                for (int n = 0; n < N_LIMBS; n++) a_d[n] = a_in[LIMB_W*n +: LIMB_W];
                for (int n = 0; n < N_COLS; n++)  col_d[n] = 64'd0;
                i_d     = 3'd0;
                j_d     = 3'd0;
                k_d     = 4'd0;
                carry_d = 64'd0;
                state_d = ST_MUL;
            end
            ST_MUL: begin
                p_d     = mul_p;
                state_d = ST_ACC;
            end
            ST_ACC: begin
                col_d[col_lo_idx] = add0_sum;
                col_d[col_hi_idx] = add1_sum;
                state_d           = ST_MUL;
                if (j_q == 3'd7) begin
                    if (i_q == 3'd7) begin
                        k_d     = 4'd0;
                        carry_d = 64'd0;
                        state_d = ST_CARRY_PROP;
                    end else begin
                        // Next row starts on its diagonal term.
                        i_d = i_q + 3'd1;
                        j_d = i_q + 3'd1;
                    end
                end else begin
                    j_d = j_q + 3'd1;
                end
            end
            ST_CARRY_PROP: begin
                col_d[k_q] = {32'b0, add0_sum[31:0]};
                carry_d    = {32'b0, add0_sum[63:32]};
                k_d        = k_q + 4'd1;
                if (k_q == 4'd15) state_d = ST_FINISH;
            end
            ST_FINISH: begin
                for (int n = 0; n < N_LIMBS; n++) begin
                    sq_low_d[LIMB_W*n +: LIMB_W]  = col_q[n][31:0];
                    sq_high_d[LIMB_W*n +: LIMB_W] = col_q[n+N_LIMBS][31:0];
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                rdy_d = 1'b1;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_LOAD;
            // NOTE: the limb and column arrays are reset as well; the outputs
            // are defined as cleared the instant reset asserts, and known
            // limbs keep the datapath free of X during bring-up.
            for (int n = 0; n < N_LIMBS; n++) a_q[n] <= '0;
            for (int n = 0; n < N_COLS; n++)  col_q[n] <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            p_q       <= '0;
            carry_q   <= '0;
            rdy_q     <= 1'b0;
            sq_high_q <= '0;
            sq_low_q  <= '0;
        end else if (ena) begin
            state_q   <= state_d;
            a_q       <= a_d;
            col_q     <= col_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            p_q       <= p_d;
            carry_q   <= carry_d;
            rdy_q     <= rdy_d;
            sq_high_q <= sq_high_d;
            sq_low_q  <= sq_low_d;
        end
    end

    assign rdy     = rdy_q;
    assign sq_high = sq_high_q;
    assign sq_low  = sq_low_q;

    // A 512-bit square cannot carry out of the top column.
    carry_out_zero: assert property (@(posedge clk) disable iff (!rst_n)
        (ena && state_q == ST_CARRY_PROP && k_q == 4'd15) |-> (add0_sum[63:32] == 32'd0));

endmodule

// File: tb/tb_p256_limb_squarer.sv
// ---------------------------------------------------------------------------
// tb_p256_limb_squarer
// Self-checking bench for p256_limb_squarer. The reference is the plain
// 512-bit product a*a; output expectations follow from counting enabled
// clock edges since reset release.
// ---------------------------------------------------------------------------
module tb_p256_limb_squarer;

    localparam int LAT = 91;

    logic         clk;
    logic         rst_n;
    logic         ena;
    logic [255:0] a_in;
    logic         rdy;
    logic [255:0] sq_high;
    logic [255:0] sq_low;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           en_cnt;
    bit           check_on = 0;
    logic [511:0] exp_sq;

    p256_limb_squarer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .a_in    (a_in),
        .rdy     (rdy),
        .sq_high (sq_high),
        .sq_low  (sq_low)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int n = 0; n < 8; n++) r[32*n +: 32] = $urandom();
        return r;
    endfunction

    // Enabled edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       en_cnt <= 0;
        else if (ena && en_cnt < 100000)  en_cnt <= en_cnt + 1;
    end

    // Single compare process: outputs are zero until the FINISH edge, the
    // square from then on, and rdy from the LAT-th enabled edge.
    always @(negedge clk) begin
        if (check_on) begin
            check("rdy", {511'b0, rdy}, {511'b0, (en_cnt >= LAT)});
            check("sq", {sq_high, sq_low}, (en_cnt >= LAT - 1) ? exp_sq : 512'b0);
        end
    end

    // One operand from reset to one edge past rdy. abort_at > 0 asserts reset
    // asynchronously partway through and returns early.
    task automatic run_op(input logic [255:0] a, input bit toggle, input int abort_at);
        int cycles;
        @(negedge clk); #1;
        rst_n  = 1'b0;
        a_in   = a;
        ena    = 1'b1;
        exp_sq = {256'b0, a} * {256'b0, a};
        @(negedge clk); #1;
        rst_n  = 1'b1;
        cycles = 0;
        while (en_cnt < LAT + 1 && cycles < 2000) begin
            @(negedge clk); #1;
            cycles++;
            ena = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            if (en_cnt >= 1) a_in = rand256();
            if (abort_at > 0 && cycles == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("abort_rdy", {511'b0, rdy}, 512'b0);
                check("abort_sq", {sq_high, sq_low}, 512'b0);
                return;
            end
        end
        if (cycles >= 2000) check("timeout", 512'd0, 512'd1);
    endtask

    logic [255:0] p_mod;
    logic [511:0] pin;

    initial begin
        rst_n = 1'b0;
        ena   = 1'b0;
        a_in  = '0;
        exp_sq = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_rdy", {511'b0, rdy}, 512'b0);
        check("reset_sq", {sq_high, sq_low}, 512'b0);
        check_on = 1'b1;

        // Hand-computed corner cases.
        run_op(256'd0, 1'b0, 0);
        check("zero_rdy", {511'b0, rdy}, {511'b0, 1'b1});
        check("zero_sq", {sq_high, sq_low}, 512'b0);

        run_op(256'd1, 1'b0, 0);
        check("one_low", {256'b0, sq_low}, 512'd1);
        check("one_high", {256'b0, sq_high}, 512'd0);

        run_op({1'b1, 255'b0}, 1'b0, 0);
        pin = {2'b01, 510'b0};
        check("msb_model", exp_sq, pin);
        check("msb_high", {256'b0, sq_high}, {256'b0, 2'b01, 254'b0});
        check("msb_low", {256'b0, sq_low}, 512'd0);

        run_op({256{1'b1}}, 1'b0, 0);
        pin = {{255{1'b1}}, 1'b0, 255'b0, 1'b1};
        check("ones_model", exp_sq, pin);
        check("ones_high", {256'b0, sq_high}, {256'b0, {255{1'b1}}, 1'b0});
        check("ones_low", {256'b0, sq_low}, 512'd1);

        // Asynchronous reset in DONE drops everything at once.
        #2 rst_n = 1'b0;
        #1;
        check("done_rst_rdy", {511'b0, rdy}, 512'b0);
        check("done_rst_sq", {sq_high, sq_low}, 512'b0);

        p_mod = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
        run_op(p_mod, 1'b0, 0);
        run_op(p_mod, 1'b1, 0);

        // Aborts mid-ACC and mid-CARRY_PROP, each followed by a clean rerun.
        run_op(rand256(), 1'b0, 40);
        run_op(rand256(), 1'b0, 0);
        run_op(rand256(), 1'b0, 80);
        run_op(rand256(), 1'b0, 0);

        // Random operands, alternating steady and randomly gated enable.
        for (int t = 0; t < 120; t++) run_op(rand256(), t[0], 0);

        check_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
